// File: rtl/tour_cmd.sv
// rtl/tour_cmd.sv - knight's-tour command sequencer muxed with the UART command path
//
// Purpose:
//   Turns a solved knight's tour into drive commands. While idle the UART
//   command path passes straight through. On start_tour the block walks the
//   24 moves of the tour. Each move becomes two commands: a vertical leg
//   (opcode 2), then a horizontal leg (opcode 3, move with fanfare). Each
//   command waits for clr_cmd_rdy (accepted) and then send_resp (finished).
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst          in   1   synchronous active-high reset
//   start_tour   in   1   one-cycle pulse: tour solution complete
//   move         in   8   one-hot move addressed by mv_indx (from solver)
//   mv_indx      out  5   index of the move being executed (0..23)
//   cmd_UART     in  16   command from the UART wrapper
//   cmd_rdy_UART in   1   UART command valid
//   cmd          out 16   {opcode[15:12], heading[11:4], squares[3:0]}
//   cmd_rdy      out  1   cmd valid
//   clr_cmd_rdy  in   1   command processor accepted cmd
//   send_resp    in   1   command processor finished the command
//   resp         out  8   response byte: 8'hA5 done/idle, 8'h5A in progress
//   tour_err     out  1   only with TOUR_CMD_MOVE_CHK_EN: one-cycle pulse on a
//                         non-one-hot move at VERT entry; the tour aborts
//
// Configuration macro: TOUR_CMD_MOVE_CHK_EN
//   Undefined (default): the lowest set bit of move is used, and 8'h00 decodes
//   as bit 0.
//   Defined: the move is validated and the tour_err port is added.

module tour_cmd (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
`ifdef TOUR_CMD_MOVE_CHK_EN
    ,
    output logic        tour_err
`endif
);

    localparam logic [4:0] LAST_MOVE = 5'd23;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    localparam logic [7:0] HDG_NORTH = 8'h00;
    localparam logic [7:0] HDG_WEST  = 8'h3F;
    localparam logic [7:0] HDG_SOUTH = 8'h7F;
    localparam logic [7:0] HDG_EAST  = 8'hBF;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VERT   = 3'd1,
        HOLD_V = 3'd2,
        HORZ   = 3'd3,
        HOLD_H = 3'd4
    } state_t;

    state_t state;

    // Move decode: the lowest set bit selects the move, so an all-zero move
    // falls through to bit 0.
    logic [2:0] mv_bit;
    logic [7:0] vert_hdg;
    logic [3:0] vert_sq;
    logic [7:0] horz_hdg;
    logic [3:0] horz_sq;

    always_comb begin
        mv_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (move[i]) begin
                mv_bit = 3'(i);
            end
        end
    end

    always_comb begin
        vert_hdg = HDG_NORTH;
        vert_sq  = 4'd2;
        horz_hdg = HDG_WEST;
        horz_sq  = 4'd1;
        case (mv_bit)
            3'd0: begin vert_hdg = HDG_NORTH; vert_sq = 4'd2; horz_hdg = HDG_WEST; horz_sq = 4'd1; end
            3'd1: begin vert_hdg = HDG_NORTH; vert_sq = 4'd2; horz_hdg = HDG_EAST; horz_sq = 4'd1; end
            3'd2: begin vert_hdg = HDG_NORTH; vert_sq = 4'd1; horz_hdg = HDG_WEST; horz_sq = 4'd2; end
            3'd3: begin vert_hdg = HDG_SOUTH; vert_sq = 4'd1; horz_hdg = HDG_WEST; horz_sq = 4'd2; end
            3'd4: begin vert_hdg = HDG_SOUTH; vert_sq = 4'd2; horz_hdg = HDG_WEST; horz_sq = 4'd1; end
            3'd5: begin vert_hdg = HDG_SOUTH; vert_sq = 4'd2; horz_hdg = HDG_EAST; horz_sq = 4'd1; end
            3'd6: begin vert_hdg = HDG_NORTH; vert_sq = 4'd1; horz_hdg = HDG_EAST; horz_sq = 4'd2; end
            3'd7: begin vert_hdg = HDG_SOUTH; vert_sq = 4'd1; horz_hdg = HDG_EAST; horz_sq = 4'd2; end
            default: ;
        endcase
    end

`ifdef TOUR_CMD_MOVE_CHK_EN
    // A legal move has exactly one bit set.
    logic move_ok;
    assign move_ok = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mv_indx <= 5'd0;
`ifdef TOUR_CMD_MOVE_CHK_EN
            tour_err <= 1'b0;
`endif
        end else begin
`ifdef TOUR_CMD_MOVE_CHK_EN
            tour_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start_tour) begin
                        state   <= VERT;
                        mv_indx <= 5'd0;
                    end
                end
                VERT: begin
`ifdef TOUR_CMD_MOVE_CHK_EN
                    // A bad move aborts the tour before it is ever offered
                    // to the command processor.
                    if (!move_ok) begin
                        state    <= IDLE;
                        tour_err <= 1'b1;
                    end else if (clr_cmd_rdy) begin
                        state <= HOLD_V;
                    end
`else
                    if (clr_cmd_rdy) begin
                        state <= HOLD_V;
                    end
`endif
                end
                HOLD_V: begin
                    if (send_resp) begin
                        state <= HORZ;
                    end
                end
                HORZ: begin
                    if (clr_cmd_rdy) begin
                        state <= HOLD_H;
                    end
                end
                HOLD_H: begin
                    if (send_resp) begin
                        if (mv_indx == LAST_MOVE) begin
                            state <= IDLE;
                        end else begin
                            mv_indx <= mv_indx + 5'd1;
                            state   <= VERT;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode from the registered state. The UART path stays
    // combinational so idle commands see no added latency.
    always_comb begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        resp    = RESP_BUSY;
        case (state)
            IDLE: begin
                cmd     = cmd_UART;
                cmd_rdy = cmd_rdy_UART;
                resp    = RESP_DONE;
            end
            VERT: begin
                cmd = {OP_MOVE, vert_hdg, vert_sq};
`ifdef TOUR_CMD_MOVE_CHK_EN
                cmd_rdy = move_ok;
`else
                cmd_rdy = 1'b1;
`endif
            end
            HOLD_V: begin
                cmd     = {OP_MOVE, vert_hdg, vert_sq};
                cmd_rdy = 1'b0;
            end
            HORZ: begin
                cmd     = {OP_FANFARE, horz_hdg, horz_sq};
                cmd_rdy = 1'b1;
            end
            HOLD_H: begin
                cmd     = {OP_FANFARE, horz_hdg, horz_sq};
                cmd_rdy = 1'b0;
                resp    = (mv_indx == LAST_MOVE) ? RESP_DONE : RESP_BUSY;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// tb/tb_tour_cmd.sv - self-checking bench for tour_cmd against a move-table reference model

module tb_tour_cmd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_tour = 1'b0;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART = 16'h0000;
    logic        cmd_rdy_UART = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;
`ifdef TOUR_CMD_MOVE_CHK_EN
    logic        tour_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] moves [24];

    // Behaves like the solver: it presents the move that mv_indx addresses.
    assign move = (mv_indx < 5'd24) ? moves[mv_indx] : 8'h00;

    always #5 clk = ~clk;

    tour_cmd dut (
        .clk          (clk),
        .rst          (rst),
        .start_tour   (start_tour),
        .move         (move),
        .mv_indx      (mv_indx),
        .cmd_UART     (cmd_UART),
        .cmd_rdy_UART (cmd_rdy_UART),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .send_resp    (send_resp),
        .resp         (resp)
`ifdef TOUR_CMD_MOVE_CHK_EN
        ,
        .tour_err     (tour_err)
`endif
    );

    // Knight move table, indexed by move bit.
    int dx_tab [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
    int dy_tab [8] = '{ 2, 2,  1, -1, -2, -2, 1, -1};

    function automatic int sel_bit(logic [7:0] m);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [15:0] exp_vert(logic [7:0] m);
        int dy;
        dy = dy_tab[sel_bit(m)];
        return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy > 0) ? dy : -dy)};
    endfunction

    function automatic logic [15:0] exp_horz(logic [7:0] m);
        int dx;
        dx = dx_tab[sel_bit(m)];
        return {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx > 0) ? dx : -dx)};
    endfunction

    function automatic logic [7:0] rand_move();
`ifdef TOUR_CMD_MOVE_CHK_EN
        return 8'(1 << $urandom_range(7));
`else
        if ($urandom_range(3) == 0) return 8'(1 << $urandom_range(7));
        if ($urandom_range(7) == 0) return 8'h00;
        return 8'($urandom);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_moves();
        for (int i = 0; i < 24; i++) moves[i] = rand_move();
    endtask

    task automatic pulse_start();
        start_tour = 1'b1;
        tick();
        start_tour = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One move's handshake. On entry the DUT is expected in VERT at index idx.
    task automatic run_move(input int idx, input bit glitch);
        logic [15:0] v;
        logic [15:0] h;
        v = exp_vert(moves[idx]);
        h = exp_horz(moves[idx]);

        vectors++;
        if (cmd_rdy !== 1'b1 || cmd !== v || mv_indx !== 5'(idx) || resp !== 8'h5A) begin
            miscompares++;
            $display("FAIL vert[%0d]: rdy=%b cmd=%h idx=%0d resp=%h, want rdy=1 cmd=%h idx=%0d resp=5a",
                     idx, cmd_rdy, cmd, mv_indx, resp, v, idx);
        end
        if (glitch) begin
            send_resp = 1'b1; start_tour = 1'b1;
            tick();
            send_resp = 1'b0; start_tour = 1'b0;
            vectors++;
            if (cmd_rdy !== 1'b1 || cmd !== v || mv_indx !== 5'(idx)) begin
                miscompares++;
                $display("FAIL vert_ignore[%0d]: rdy=%b cmd=%h idx=%0d, want rdy=1 cmd=%h idx=%0d",
                         idx, cmd_rdy, cmd, mv_indx, v, idx);
            end
        end

        clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
        vectors++;
        if (cmd_rdy !== 1'b0 || cmd !== v || resp !== 8'h5A) begin
            miscompares++;
            $display("FAIL hold_v[%0d]: rdy=%b cmd=%h resp=%h, want rdy=0 cmd=%h resp=5a", idx, cmd_rdy, cmd, resp, v);
        end
        if (glitch) begin
            clr_cmd_rdy = 1'b1; start_tour = 1'b1;
            tick();
            clr_cmd_rdy = 1'b0; start_tour = 1'b0;
            vectors++;
            if (cmd_rdy !== 1'b0 || cmd !== v) begin
                miscompares++;
                $display("FAIL hold_v_ignore[%0d]: rdy=%b cmd=%h, want rdy=0 cmd=%h", idx, cmd_rdy, cmd, v);
            end
        end

        send_resp = 1'b1; tick(); send_resp = 1'b0;
        vectors++;
        if (cmd_rdy !== 1'b1 || cmd !== h || resp !== 8'h5A) begin
            miscompares++;
            $display("FAIL horz[%0d]: rdy=%b cmd=%h resp=%h, want rdy=1 cmd=%h resp=5a", idx, cmd_rdy, cmd, resp, h);
        end

        clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
        vectors++;
        if (cmd_rdy !== 1'b0 || cmd !== h || resp !== ((idx == 23) ? 8'hA5 : 8'h5A)) begin
            miscompares++;
            $display("FAIL hold_h[%0d]: rdy=%b cmd=%h resp=%h, want rdy=0 cmd=%h resp=%h",
                     idx, cmd_rdy, cmd, resp, h, (idx == 23) ? 8'hA5 : 8'h5A);
        end

        send_resp = 1'b1; tick(); send_resp = 1'b0;
    endtask

    task automatic test_reset();
        cmd_UART = 16'h1234; cmd_rdy_UART = 1'b0;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        vectors++;
        if (mv_indx !== 5'd0 || cmd_rdy !== 1'b0 || cmd !== 16'h1234 || resp !== 8'hA5) begin
            miscompares++;
            $display("FAIL reset: idx=%0d rdy=%b cmd=%h resp=%h, want idx=0 rdy=0 cmd=1234 resp=a5",
                     mv_indx, cmd_rdy, cmd, resp);
        end
`ifdef TOUR_CMD_MOVE_CHK_EN
        vectors++;
        if (tour_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: tour_err=%b, want 0", tour_err);
        end
`endif
    endtask

    task automatic test_idle_passthrough();
        cmd_UART = 16'h2003; cmd_rdy_UART = 1'b1;
        tick();
        vectors++;
        if (cmd !== 16'h2003 || cmd_rdy !== 1'b1 || resp !== 8'hA5) begin
            miscompares++;
            $display("FAIL idle_2003: cmd=%h rdy=%b resp=%h, want cmd=2003 rdy=1 resp=a5", cmd, cmd_rdy, resp);
        end
        for (int i = 0; i < 6; i++) begin
            cmd_UART = 16'($urandom); cmd_rdy_UART = 1'($urandom);
            clr_cmd_rdy = 1'($urandom); send_resp = 1'($urandom);
            tick();
            vectors++;
            if (cmd !== cmd_UART || cmd_rdy !== cmd_rdy_UART || resp !== 8'hA5 || mv_indx !== 5'd0) begin
                miscompares++;
                $display("FAIL idle_rand[%0d]: cmd=%h rdy=%b resp=%h idx=%0d, want cmd=%h rdy=%b resp=a5 idx=0",
                         i, cmd, cmd_rdy, resp, mv_indx, cmd_UART, cmd_rdy_UART);
            end
        end
        clr_cmd_rdy = 1'b0; send_resp = 1'b0; cmd_rdy_UART = 1'b0;
    endtask

    task automatic test_directed_moves();
        logic [7:0] dm [2] = '{8'h01, 8'h80};
        logic [15:0] dv [2] = '{16'h2002, 16'h27F1};
        logic [15:0] dh [2] = '{16'h33F1, 16'h3BF2};
        for (int k = 0; k < 2; k++) begin
            moves[0] = dm[k];
            pulse_start();
            vectors++;
            if (cmd !== dv[k] || cmd_rdy !== 1'b1) begin
                miscompares++;
                $display("FAIL dir_vert[%h]: cmd=%h rdy=%b, want cmd=%h rdy=1", dm[k], cmd, cmd_rdy, dv[k]);
            end
            clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
            send_resp = 1'b1; tick(); send_resp = 1'b0;
            vectors++;
            if (cmd !== dh[k] || cmd_rdy !== 1'b1) begin
                miscompares++;
                $display("FAIL dir_horz[%h]: cmd=%h rdy=%b, want cmd=%h rdy=1", dm[k], cmd, cmd_rdy, dh[k]);
            end
            do_reset();
        end
    endtask

    task automatic test_full_tour();
        fill_moves();
        cmd_UART = 16'hBEEF; cmd_rdy_UART = 1'b0;
        pulse_start();
        for (int i = 0; i < 24; i++) run_move(i, 1'($urandom_range(2) == 0));
        vectors++;
        if (cmd !== 16'hBEEF || cmd_rdy !== 1'b0 || resp !== 8'hA5 || mv_indx !== 5'd23) begin
            miscompares++;
            $display("FAIL tour_end: cmd=%h rdy=%b resp=%h idx=%0d, want cmd=beef rdy=0 resp=a5 idx=23",
                     cmd, cmd_rdy, resp, mv_indx);
        end
        send_resp = 1'b1; clr_cmd_rdy = 1'b1; tick(); tick();
        send_resp = 1'b0; clr_cmd_rdy = 1'b0;
        vectors++;
        if (mv_indx !== 5'd23 || cmd_rdy !== 1'b0 || resp !== 8'hA5) begin
            miscompares++;
            $display("FAIL tour_hold: idx=%0d rdy=%b resp=%h, want idx=23 rdy=0 resp=a5", mv_indx, cmd_rdy, resp);
        end
    endtask

    task automatic test_reset_mid_tour();
        fill_moves();
        cmd_UART = 16'h4321; cmd_rdy_UART = 1'b0;
        pulse_start();
        for (int i = 0; i < 7; i++) run_move(i, 1'b0);
        clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
        vectors++;
        if (mv_indx !== 5'd7 || cmd_rdy !== 1'b0 || cmd !== exp_vert(moves[7])) begin
            miscompares++;
            $display("FAIL pre_rst: idx=%0d rdy=%b cmd=%h, want idx=7 rdy=0 cmd=%h", mv_indx, cmd_rdy, cmd, exp_vert(moves[7]));
        end
        do_reset();
        vectors++;
        if (mv_indx !== 5'd0 || cmd !== 16'h4321 || cmd_rdy !== 1'b0 || resp !== 8'hA5) begin
            miscompares++;
            $display("FAIL mid_rst: idx=%0d cmd=%h rdy=%b resp=%h, want idx=0 cmd=4321 rdy=0 resp=a5",
                     mv_indx, cmd, cmd_rdy, resp);
        end
        send_resp = 1'b1; clr_cmd_rdy = 1'b1; tick(); tick(); tick();
        send_resp = 1'b0; clr_cmd_rdy = 1'b0;
        vectors++;
        if (mv_indx !== 5'd0 || cmd_rdy !== 1'b0 || cmd !== 16'h4321) begin
            miscompares++;
            $display("FAIL no_resume: idx=%0d rdy=%b cmd=%h, want idx=0 rdy=0 cmd=4321", mv_indx, cmd_rdy, cmd);
        end
        pulse_start();
        run_move(0, 1'b0);
        run_move(1, 1'b1);
        vectors++;
        if (mv_indx !== 5'd2 || cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL restart: idx=%0d rdy=%b, want idx=2 rdy=1", mv_indx, cmd_rdy);
        end
        do_reset();
    endtask

    task automatic test_same_cycle();
        moves[0] = rand_move();
        cmd_UART = 16'($urandom); cmd_rdy_UART = 1'b1; start_tour = 1'b1;
        #1;
        vectors++;
        if (cmd !== cmd_UART || cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL same_cyc_uart: cmd=%h rdy=%b, want cmd=%h rdy=1", cmd, cmd_rdy, cmd_UART);
        end
        tick();
        start_tour = 1'b0;
        vectors++;
        if (cmd !== exp_vert(moves[0]) || cmd_rdy !== 1'b1 || mv_indx !== 5'd0 || resp !== 8'h5A) begin
            miscompares++;
            $display("FAIL same_cyc_tour: cmd=%h rdy=%b idx=%0d resp=%h, want cmd=%h rdy=1 idx=0 resp=5a",
                     cmd, cmd_rdy, mv_indx, resp, exp_vert(moves[0]));
        end
        cmd_rdy_UART = 1'b0;
        do_reset();
    endtask

`ifdef TOUR_CMD_MOVE_CHK_EN
    task automatic test_move_chk();
        moves[0] = 8'h03;
        cmd_rdy_UART = 1'b0;
        pulse_start();
        vectors++;
        if (cmd_rdy !== 1'b0 || tour_err !== 1'b0) begin
            miscompares++;
            $display("FAIL chk_entry: rdy=%b err=%b, want rdy=0 err=0", cmd_rdy, tour_err);
        end
        tick();
        vectors++;
        if (tour_err !== 1'b1 || cmd_rdy !== 1'b0 || resp !== 8'hA5) begin
            miscompares++;
            $display("FAIL chk_pulse: err=%b rdy=%b resp=%h, want err=1 rdy=0 resp=a5", tour_err, cmd_rdy, resp);
        end
        tick();
        vectors++;
        if (tour_err !== 1'b0 || cmd_rdy !== 1'b0 || resp !== 8'hA5) begin
            miscompares++;
            $display("FAIL chk_after: err=%b rdy=%b resp=%h, want err=0 rdy=0 resp=a5", tour_err, cmd_rdy, resp);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 24; i++) moves[i] = 8'h01;
        test_reset();
        test_idle_passthrough();
        test_directed_moves();
        test_full_tour();
        test_reset_mid_tour();
        test_same_cycle();
`ifdef TOUR_CMD_MOVE_CHK_EN
        test_move_chk();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port start_tour, input, 1, one-cycle pulse from the tour solver meaning the solution is complete.
REQ-004 SHALL have port move, input, 8, one-hot move addressed by mv_indx, combinational from the solver.
REQ-005 SHALL have port mv_indx, output, 5, registered index of the move being executed (0..23).
REQ-006 SHALL have port cmd_UART, input, 16, command from the UART wrapper.
REQ-007 SHALL have port cmd_rdy_UART, input, 1, UART command valid.
REQ-008 SHALL have port cmd, output, 16, command to the command processor, formatted as opcode[15:12], heading[11:4], squares[3:0].
REQ-009 SHALL have port cmd_rdy, output, 1, cmd valid.
REQ-010 SHALL have port clr_cmd_rdy, input, 1, command processor has accepted cmd.
REQ-011 SHALL have port send_resp, input, 1, command processor has finished executing the command.
REQ-012 SHALL have port resp, output, 8, response byte for the UART.

Function
REQ-013 SHALL implement states IDLE, VERT, HOLD_V, HORZ and HOLD_H.
REQ-014 In IDLE, SHALL pass through the UART path: cmd=cmd_UART and cmd_rdy=cmd_rdy_UART.
REQ-015 In IDLE, start_tour SHALL cause the transition IDLE->VERT and clear mv_indx to 0; cmd_rdy SHALL assert on the next cycle.
REQ-016 start_tour SHALL be ignored outside IDLE.
REQ-017 When start_tour and cmd_rdy_UART assert in the same cycle, the tour SHALL win from the next cycle onward.
REQ-018 Move decode SHALL use bit index to (dx,dy): 0:(-1,+2), 1:(+1,+2), 2:(-2,+1), 3:(-2,-1), 4:(-1,-2), 5:(+1,-2), 6:(+2,+1), 7:(+2,-1).
REQ-019 In VERT/HOLD_V, cmd SHALL be {4'h2, heading, |dy|}, with heading north=8'h00 for dy>0 and south=8'h7F for dy<0.
REQ-020 In HORZ/HOLD_H, cmd SHALL be {4'h3, heading, |dx|}, with heading east=8'hBF for dx>0 and west=8'h3F for dx<0; opcode 3 means move with fanfare.
REQ-021 cmd_rdy SHALL be high in VERT and HORZ only.
REQ-022 clr_cmd_rdy SHALL cause VERT->HOLD_V and HORZ->HOLD_H.
REQ-023 send_resp SHALL cause HOLD_V->HORZ.
REQ-024 send_resp in HOLD_H SHALL cause: if mv_indx==23, ->IDLE with mv_indx held; otherwise mv_indx+1 and ->VERT.
REQ-025 send_resp or clr_cmd_rdy arriving in a state that does not wait for it SHALL be ignored.
REQ-026 resp SHALL be 8'hA5 in IDLE and in HOLD_H when mv_indx==23; otherwise resp SHALL be 8'h5A.
REQ-027 mv_indx SHALL never exceed 23 and SHALL never wrap.

Reset
REQ-028 rst SHALL force state=IDLE and mv_indx=0 at the next clock edge, including mid-tour; cmd and cmd_rdy SHALL then follow the UART path.
REQ-029 A tour aborted by rst SHALL NOT resume; a fresh start_tour SHALL be required.

Configuration
REQ-030 With TOUR_CMD_MOVE_CHK_EN defined, SHALL add output tour_err (1 bit, reset 0).
REQ-031 With TOUR_CMD_MOVE_CHK_EN defined, a non-one-hot move on entry to VERT SHALL pulse tour_err for one cycle and return to IDLE without asserting cmd_rdy.
REQ-032 Without TOUR_CMD_MOVE_CHK_EN, port tour_err SHALL be absent and the lowest set bit of move SHALL be used.
REQ-033 Without TOUR_CMD_MOVE_CHK_EN, move==8'h00 SHALL decode as bit 0.

Verification
REQ-034 Bench SHALL cover: idle with cmd_UART=16'h2003, cmd_rdy_UART=1 -> cmd=16'h2003, cmd_rdy=1, resp=8'hA5.
REQ-035 Bench SHALL cover: start_tour with move=8'h01 -> cmd=16'h2002, then after clr/send, cmd=16'h33F1.
REQ-036 Bench SHALL cover: move=8'h80 -> cmd=16'h27F1, then cmd=16'h3BF2.
REQ-037 Bench SHALL cover: a full 24-move handshake sequence -> mv_indx 0..23; resp=8'h5A until the last HOLD_H, which gives 8'hA5; then IDLE.
REQ-038 Bench SHALL cover: rst asserted in HOLD_V at mv_indx=7 -> IDLE and mv_indx=0 next cycle; a later start_tour restarts at index 0.
REQ-039 Bench SHALL cover, with TOUR_CMD_MOVE_CHK_EN: move=8'h03 at start -> tour_err one-cycle pulse, cmd_rdy stays 0, state IDLE.
